// File: rtl/spi_master_queue.sv
// Paced byte feeder for an SPI master: TX FIFO -> fixed-length spi_on windows -> RX FIFO.
// Both FIFOs keep a registered head in front of the storage array, so reads are always registered.
module spi_master_queue #(
    parameter int DEPTH       = 8,
    parameter int XFER_CYCLES = 18,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic                   spi_on,
    output logic [7:0]             spi_data_tx,
    input  logic [7:0]             spi_data_rx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] tx_level
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_INC   = CW'(1);
    localparam logic [CW-1:0] XFER_LAST = CW'(XFER_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr_reg, tx_rptr_reg;
    logic [AW:0]   tx_cnt_reg;
    logic [7:0]    tx_head_reg;
    logic          tx_head_vld_reg;
    logic          tx_push, tx_pop, tx_load;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr_reg, rx_rptr_reg;
    logic [AW:0]   rx_cnt_reg, rx_total;
    logic          rx_push, rx_pop, rx_load, rx_room;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          start, capture;

    // Occupancy = entries in the array plus the prefetched head register.
    assign tx_level = tx_cnt_reg + {{AW{1'b0}}, tx_head_vld_reg};
    assign wr_ready = (tx_level != FULL);
    assign tx_push  = wr_valid && wr_ready;
    assign tx_pop   = start;
    assign tx_load  = (tx_cnt_reg != '0) && (!tx_head_vld_reg || tx_pop);

    // RX space is judged on total occupancy; a start only happens from IDLE, so nothing is in flight then.
    assign rx_total = rx_cnt_reg + {{AW{1'b0}}, rd_valid};
    assign rx_room  = (rx_total != FULL);
    assign rx_pop   = rd_valid && rd_ready;
    assign rx_push  = capture;
    assign rx_load  = (rx_cnt_reg != '0) && (!rd_valid || rx_pop);

    assign start   = (state_reg == IDLE) && tx_head_vld_reg && rx_room;
    assign capture = (state_reg == XFER) && (cnt_reg == XFER_LAST);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_reg] <= wr_data;
        if (tx_load) tx_head_reg <= tx_mem[tx_rptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_reg] <= spi_data_rx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_reg     <= '0;
            tx_rptr_reg     <= '0;
            tx_cnt_reg      <= '0;
            tx_head_vld_reg <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_reg <= tx_wptr_reg + PTR_ONE;
            if (tx_load) tx_rptr_reg <= tx_rptr_reg + PTR_ONE;
            case ({tx_push, tx_load})
                2'b10:   tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
                2'b01:   tx_cnt_reg <= tx_cnt_reg - CNT_ONE;
                default: ;
            endcase
            if (tx_load)     tx_head_vld_reg <= 1'b1;
            else if (tx_pop) tx_head_vld_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_reg <= '0;
            rx_rptr_reg <= '0;
            rx_cnt_reg  <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
        end else begin
            if (rx_push) rx_wptr_reg <= rx_wptr_reg + PTR_ONE;
            if (rx_load) rx_rptr_reg <= rx_rptr_reg + PTR_ONE;
            case ({rx_push, rx_load})
                2'b10:   rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                2'b01:   rx_cnt_reg <= rx_cnt_reg - CNT_ONE;
                default: ;
            endcase
            if (rx_load) begin
                rd_data  <= rx_mem[rx_rptr_reg];
                rd_valid <= 1'b1;
            end else if (rx_pop) begin
                rd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            spi_on      <= 1'b0;
            spi_data_tx <= 8'h00;
            busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        spi_on      <= 1'b1;
                        spi_data_tx <= tx_head_reg;
                        cnt_reg     <= '0;
                        busy        <= 1'b1;
                        state_reg   <= XFER;
                    end
                end
                XFER: begin
                    if (capture) begin
                        spi_on    <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_INC;
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg   <= '0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_INC;
                    end
                end
                default: begin
                    spi_on    <= 1'b0;
                    cnt_reg   <= '0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
